// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and constants for the configuration stream loader
package cfg_pkg;

    typedef enum logic [2:0] {
        HDR,
        PAY,
        CHK,
        DONE,
        ERR
    } cfg_state_e;

    localparam int DATA_W_DEF  = 33;
    localparam int SW_W_DEF    = 16;
    localparam int NUM_LUT_DEF = 16;
    localparam int NUM_SW_DEF  = 32;
    localparam int ADDR_W_DEF  = 8;

    localparam logic [8:0] SYNC_PAT = 9'h1A5;

    // Header word layout
    localparam int HDR_SYNC_MSB = 32;
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_ADDR_MSB = 15;
    localparam int HDR_ADDR_LSB = 8;
    localparam int HDR_CNT_MSB  = 7;
    localparam int HDR_CNT_LSB  = 0;

    // Region bases shared with the fabric element write ports
    localparam int LUT_BASE_DEF = 0;
    localparam int SW_BASE_DEF  = NUM_LUT_DEF;

endpackage

// File: rtl/cfg_addr_decode.sv
// rtl/cfg_addr_decode.sv - element address to region write-strobe decoder with range check
module cfg_addr_decode
    import cfg_pkg::*;
#(
    parameter int NUM_LUT = NUM_LUT_DEF,
    parameter int NUM_SW  = NUM_SW_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic [ADDR_W:0] addr,
    input  logic            en,
    output logic            we_lut,
    output logic            we_sw,
    output logic            in_range
);

    localparam int              SW_END_I = NUM_LUT + NUM_SW;
    localparam logic [ADDR_W:0] SW_BASE  = NUM_LUT[ADDR_W:0];
    localparam logic [ADDR_W:0] SW_END   = SW_END_I[ADDR_W:0];

    logic below_sw;

    assign below_sw = (addr < SW_BASE);
    assign in_range = (addr < SW_END);
    assign we_lut   = en & below_sw;
    assign we_sw    = en & ~below_sw & in_range;

endmodule

// File: rtl/cfg_stream_loader.sv
// rtl/cfg_stream_loader.sv - loads LUT and switch-box configuration from a checksummed word stream
module cfg_stream_loader
    import cfg_pkg::*;
#(
    parameter int         DATA_W  = DATA_W_DEF,
    parameter int         SW_W    = SW_W_DEF,
    parameter int         NUM_LUT = NUM_LUT_DEF,
    parameter int         NUM_SW  = NUM_SW_DEF,
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter logic [8:0] SYNC    = SYNC_PAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    output logic              cfg_we_lut,
    output logic              cfg_we_sw,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              fabric_en
);

    localparam int              TOTAL_I = NUM_LUT + NUM_SW;
    localparam logic [ADDR_W:0] TOTAL   = TOTAL_I[ADDR_W:0];
    // Switch boxes only see the low SW_W bits; upper bits are zeroed on their writes
    localparam logic [DATA_W-1:0] SW_MASK = {{(DATA_W-SW_W){1'b0}}, {SW_W{1'b1}}};

    cfg_state_e state, state_nxt;

    logic [ADDR_W:0]   base_q;
    logic [7:0]        cnt_q;
    logic [7:0]        idx_q;
    logic [DATA_W-1:0] acc_q;

    logic              accept;
    logic [7:0]        hdr_addr;
    logic [7:0]        hdr_cnt;
    logic              hdr_sync_ok;
    logic              hdr_fits;
    logic              last_word;
    logic [ADDR_W:0]   pay_addr;
    logic              dec_lut;
    logic              dec_sw;
    logic              dec_in_range;

    assign in_ready    = ~rst & ((state == HDR) | (state == PAY) | (state == CHK));
    assign accept      = in_valid & in_ready;
    assign hdr_addr    = in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign hdr_cnt     = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
    assign hdr_sync_ok = (in_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == SYNC);
    assign hdr_fits    = (({1'b0, hdr_addr} + {1'b0, hdr_cnt}) <= TOTAL);
    assign last_word   = (idx_q == (cnt_q - 8'd1));
    assign pay_addr    = base_q + {1'b0, idx_q};

    cfg_addr_decode #(
        .NUM_LUT (NUM_LUT),
        .NUM_SW  (NUM_SW),
        .ADDR_W  (ADDR_W)
    ) u_decode (
        .addr     (pay_addr),
        .en       (accept & (state == PAY)),
        .we_lut   (dec_lut),
        .we_sw    (dec_sw),
        .in_range (dec_in_range)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (accept) begin
                    if (!hdr_sync_ok)         state_nxt = ERR;
                    else if (hdr_cnt == 8'd0) state_nxt = DONE;
                    else if (!hdr_fits)       state_nxt = ERR;
                    else                      state_nxt = PAY;
                end
            end
            PAY: begin
                if (accept) begin
                    if (!dec_in_range)  state_nxt = ERR;
                    else if (last_word) state_nxt = CHK;
                end
            end
            CHK: begin
                if (accept) state_nxt = (in_data == acc_q) ? HDR : ERR;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            cfg_addr   <= '0;
            cfg_data   <= '0;
            cfg_we_lut <= 1'b0;
            cfg_we_sw  <= 1'b0;
        end else begin
            cfg_we_lut <= 1'b0;
            cfg_we_sw  <= 1'b0;
            if (accept) begin
                case (state)
                    HDR: begin
                        base_q <= {1'b0, hdr_addr};
                        cnt_q  <= hdr_cnt;
                        idx_q  <= '0;
                        acc_q  <= '0;
                    end
                    PAY: begin
                        acc_q      <= acc_q ^ in_data;
                        idx_q      <= idx_q + 8'd1;
                        cfg_addr   <= pay_addr[ADDR_W-1:0];
                        cfg_data   <= dec_sw ? (in_data & SW_MASK) : in_data;
                        cfg_we_lut <= dec_lut;
                        cfg_we_sw  <= dec_sw;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cfg_done  = (state == DONE);
    assign cfg_err   = (state == ERR);
    assign fabric_en = cfg_done & ~cfg_err;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb/tb_cfg_stream_loader.sv - directed table-driven bench for cfg_stream_loader
module tb_cfg_stream_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  cfg_addr;
    logic [32:0] cfg_data;
    logic        cfg_we_lut;
    logic        cfg_we_sw;
    logic        cfg_done;
    logic        cfg_err;
    logic        fabric_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cfg_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_we_lut (cfg_we_lut),
        .cfg_we_sw  (cfg_we_sw),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .fabric_en  (fabric_en)
    );

    // flags = {we_lut, we_sw, in_ready, done, err, fabric_en}
    localparam logic [5:0] F_RST  = 6'b000000;
    localparam logic [5:0] F_IDLE = 6'b001000;
    localparam logic [5:0] F_LUT  = 6'b101000;
    localparam logic [5:0] F_SW   = 6'b011000;
    localparam logic [5:0] F_DONE = 6'b000101;
    localparam logic [5:0] F_ERR  = 6'b000010;

    typedef struct {
        logic        r;
        logic        vld;
        logic [32:0] d;
        logic [5:0]  flags;
        logic        chk_ad;
        logic [7:0]  addr;
        logic [32:0] wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [32:0] hdr(input logic [7:0] a, input logic [7:0] n);
        return {9'h1A5, 8'h00, a, n};
    endfunction

    function automatic vec_t mk(input logic r, input logic vld, input logic [32:0] d,
                                input logic [5:0] f, input logic ca,
                                input logic [7:0] a, input logic [32:0] wd);
        vec_t v;
        v.r = r; v.vld = vld; v.d = d; v.flags = f; v.chk_ad = ca; v.addr = a; v.wdata = wd;
        return v;
    endfunction

    task automatic cycle(input logic r, input logic vld, input logic [32:0] d);
        @(negedge clk);
        rst = r;
        in_valid = vld;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags_now();
        return {cfg_we_lut, cfg_we_sw, in_ready, cfg_done, cfg_err, fabric_en};
    endfunction

    initial begin
        // reset and single LUT block
        vecs.push_back(mk(1, 0, 33'h0, F_RST, 1, 8'd0, 33'h0));
        vecs.push_back(mk(0, 0, 33'h0, F_IDLE, 1, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd0, 8'd2), F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_0000_1234, F_LUT, 1, 8'd0, 33'h0_0000_1234));
        vecs.push_back(mk(0, 1, 33'h1_0000_00FF, F_LUT, 1, 8'd1, 33'h1_0000_00FF));
        vecs.push_back(mk(0, 1, 33'h1_0000_12CB, F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd0, 8'd0), F_DONE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 0, 33'h0, F_DONE, 0, 8'd0, 33'h0));
        // block straddling the LUT / switch boundary
        vecs.push_back(mk(1, 0, 33'h0, F_RST, 1, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd15, 8'd2), F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_1234_5678, F_LUT, 1, 8'd15, 33'h0_1234_5678));
        vecs.push_back(mk(0, 1, 33'h1_CAFE_BEEF, F_SW, 1, 8'd16, 33'h0_0000_BEEF));
        vecs.push_back(mk(0, 1, 33'h1_D8CA_E897, F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd0, 8'd0), F_DONE, 0, 8'd0, 33'h0));
        // bad checksum after one switch write
        vecs.push_back(mk(1, 0, 33'h0, F_RST, 1, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd20, 8'd1), F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_0000_0005, F_SW, 1, 8'd20, 33'h0_0000_0005));
        vecs.push_back(mk(0, 1, 33'h0_0000_0004, F_ERR, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_0000_0000, F_ERR, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd0, 8'd0), F_ERR, 0, 8'd0, 33'h0));
        // bad sync, then out-of-range header
        vecs.push_back(mk(1, 0, 33'h0, F_RST, 1, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, {9'h0FF, 24'h00_01_02}, F_ERR, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_0000_0001, F_ERR, 0, 8'd0, 33'h0));
        vecs.push_back(mk(1, 0, 33'h0, F_RST, 1, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd40, 8'd9), F_ERR, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_0000_0001, F_ERR, 0, 8'd0, 33'h0));
        // stall 1-0-0-1 inside a payload
        vecs.push_back(mk(1, 0, 33'h0, F_RST, 1, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd2, 8'd2), F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_0000_00AA, F_LUT, 1, 8'd2, 33'h0_0000_00AA));
        vecs.push_back(mk(0, 0, 33'h0_0000_0077, F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 0, 33'h0_0000_0066, F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, 33'h0_0000_0055, F_LUT, 1, 8'd3, 33'h0_0000_0055));
        vecs.push_back(mk(0, 1, 33'h0_0000_00FF, F_IDLE, 0, 8'd0, 33'h0));
        vecs.push_back(mk(0, 1, hdr(8'd0, 8'd0), F_DONE, 0, 8'd0, 33'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r, vecs[i].vld, vecs[i].d);
            check($sformatf("vec%0d flags", i), 64'(flags_now()), 64'(vecs[i].flags));
            if (vecs[i].chk_ad) begin
                check($sformatf("vec%0d addr", i), 64'(cfg_addr), 64'(vecs[i].addr));
                check($sformatf("vec%0d data", i), 64'(cfg_data), 64'(vecs[i].wdata));
            end
        end

        // reset after the first of four payload words
        cycle(1, 0, 33'h0);
        cycle(0, 1, hdr(8'd4, 8'd4));
        cycle(0, 1, 33'h0_0000_0011);
        check("midrst first strobe", 64'(flags_now()), 64'(F_LUT));
        check("midrst first addr", 64'(cfg_addr), 64'd4);
        cycle(1, 1, 33'h0_0000_0022);
        check("midrst reset flags", 64'(flags_now()), 64'(F_RST));
        check("midrst reset addr", 64'(cfg_addr), 64'd0);
        check("midrst reset data", 64'(cfg_data), 64'd0);
        cycle(0, 0, 33'h0);
        check("midrst idle after", 64'(flags_now()), 64'(F_IDLE));
        cycle(0, 1, hdr(8'd4, 8'd1));
        check("reload hdr", 64'(flags_now()), 64'(F_IDLE));
        cycle(0, 1, 33'h1_5555_AAAA);
        check("reload strobe", 64'(flags_now()), 64'(F_LUT));
        check("reload addr", 64'(cfg_addr), 64'd4);
        check("reload data", 64'(cfg_data), 64'h1_5555_AAAA);
        cycle(0, 1, 33'h1_5555_AAAA);
        check("reload chk", 64'(flags_now()), 64'(F_IDLE));
        cycle(0, 1, hdr(8'd0, 8'd0));
        check("reload done", 64'(flags_now()), 64'(F_DONE));
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, hdr(8'd0, 8'd2));
            check($sformatf("done hold %0d", k), 64'(flags_now()), 64'(F_DONE));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Upstream configuration stage for the FPGA fabric.
- Accepts a word stream carrying LUT contents and switch-box routing words, then drives per-element write strobes into the fabric's LUT `mem` registers and switch-box `configure` registers.
- Replaces direct preloading of fabric state; once the stream validates, it raises `fabric_en` to release the fabric into operation.

Parameters:
- DATA_W, 33, stream/LUT word width (LUT `mem` width).
- SW_W, 16, switch-box configure width (low bits of the data word).
- NUM_LUT, 16, LUT elements, addresses 0..NUM_LUT-1.
- NUM_SW, 32, switch-box elements, addresses NUM_LUT..NUM_LUT+NUM_SW-1.
- ADDR_W, 8, element address width.
- SYNC, 9'h1A5, header sync pattern in bits [32:24].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  DATA_W  stream word
- in_valid  in  1  word valid
- in_ready  out  1  loader can accept a word
- cfg_addr  out  ADDR_W  element address of current write
- cfg_data  out  DATA_W  write data; switch boxes use [SW_W-1:0]
- cfg_we_lut  out  1  one-cycle write strobe, LUT region
- cfg_we_sw  out  1  one-cycle write strobe, switch region
- cfg_done  out  1  load completed and validated (sticky)
- cfg_err  out  1  protocol/checksum error (sticky)
- fabric_en  out  1  fabric may run; equals cfg_done & ~cfg_err

Behaviour:
- Clock and reset:
  - One clock `clk`; reset `rst` is synchronous and active-high.
  - Reset values: in_ready=0 in the reset cycle, then 1; cfg_we_*=0, cfg_addr=0, cfg_data=0, cfg_done=0, cfg_err=0, fabric_en=0; state=HDR.
  - Reset mid-load aborts immediately. No further strobes are issued. Fabric contents already written are left as they are.
- Handshake:
  - A word transfers when in_valid & in_ready at a rising clk edge.
  - in_ready is 1 in HDR, PAY and CHK; it is 0 in DONE and ERR.
- Header word:
  - [32:24] = sync pattern.
  - [15:8] = start address A.
  - [7:0] = count N.
  - Bits [23:16] are ignored.
- States:
  - HDR:
    - Sync mismatch -> ERR.
    - N==0 -> DONE (end-of-stream marker).
    - Otherwise latch A and N, clear the XOR accumulator, go to PAY.
  - PAY:
    - Each accepted word is written to address A+i, i = 0..N-1.
    - Each word is XORed into the accumulator.
    - After the N-th word -> CHK.
  - CHK:
    - The accepted word must equal the accumulator.
    - Equal -> HDR (next block). Mismatch -> ERR.
  - DONE: cfg_done=1 and fabric_en=1; holds until rst.
  - ERR: cfg_err=1 and fabric_en=0; holds until rst.
- Write timing:
  - A payload word accepted at edge k produces cfg_addr/cfg_data valid and exactly one strobe high during cycle k+1 (latency 1, registered).
  - Back-to-back words give back-to-back strobes.
- Region decode:
  - addr < NUM_LUT -> cfg_we_lut.
  - NUM_LUT <= addr < NUM_LUT+NUM_SW -> cfg_we_sw.
- Range check:
  - Checked at the header: A+N > NUM_LUT+NUM_SW -> ERR, with no payload writes.
  - A block may straddle the LUT/switch boundary; the strobe region follows each word's own address.
  - Address arithmetic is ADDR_W+1 bits wide, with no wrap.
- Stalls: in_valid low stalls any state without side effects; no strobes are issued while stalled.
- Writes already issued before a checksum failure are not undone. fabric_en stays low, so the fabric never runs on a bad image.

Decomposition:
- Shared package cfg_pkg holds:
  - state enum {HDR, PAY, CHK, DONE, ERR};
  - SYNC constant;
  - header field bit positions;
  - NUM_LUT/NUM_SW defaults and region-base constants, reused by the fabric top.
- One natural sub-module, cfg_addr_decode: a combinational address-to-region strobe decoder with range check. It is shared with the fabric's element write ports.

Test Plan:
- Single LUT block:
  - Stimulus: header {1A5, A=0, N=2}, payload 33'h0_0000_1234 and 33'h1_0000_00FF, checksum = their XOR, then header N=0.
  - Required: cfg_we_lut pulses at addr 0 then 1 with the exact data; cfg_done=1, fabric_en=1, cfg_err=0.
- Straddling block:
  - Stimulus: A=15, N=2.
  - Required: addr 15 raises cfg_we_lut, addr 16 raises cfg_we_sw; switch data low 16 bits = 16'hBEEF.
- Bad checksum:
  - Stimulus: A=20, N=1, data 5, checksum 4.
  - Required: one cfg_we_sw at addr 20; then cfg_err=1, in_ready=0, fabric_en=0 indefinitely.
- Bad sync and out-of-range:
  - Stimulus: header [32:24]=9'h0FF -> cfg_err=1 with no strobes. After rst, header A=40, N=9 (49 > 48) -> cfg_err=1 with no strobes.
- Stall and reset mid-load:
  - Stimulus: payload with in_valid toggled 1-0-0-1 -> exactly one strobe per accepted word.
  - Stimulus: rst asserted after the first of N=4 words -> the next cycle shows all outputs at reset values and no strobes. A fresh valid stream then loads correctly.
